rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage; sits between the fetch stage and the execute/ALU stage.
- Decodes one instruction per cycle into ALU op, operand/writeback selects, immediate and register indices, then holds them in the ID/EX register.
- Adds behaviour the combinational controller lacks: valid/ready handshake with back-pressure, load-use interlock (configurable latency), flush/squash, illegal-instruction flagging, optional M-extension decode.

Parameters:
- XLEN, 32, datapath/immediate/PC width (32 only legal value this generation; kept for the 64-bit follow-on).
- EN_M_EXT, 0, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = those encodings flagged illegal.
- LOAD_LAT, 1, cycles a load result is unavailable to a dependent instruction (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts if_instr this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- ex_flush  in  1  taken branch/jump resolved in EX; squash younger work
- ex_ready  in  1  EX accepts the ID/EX register contents
- id_valid  out  1  ID/EX register holds a live instruction
- id_pc  out  XLEN  registered PC
- id_alu_op  out  7  ALU opcode (package encoding)
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_imm  out  XLEN  sign/zero-formatted immediate (I/S/B/U/J)
- id_op1_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- id_op2_sel  out  2  0 = rs2, 1 = imm, 2 = const 4
- id_wb_sel  out  3  0 = ALU, 1 = LW, 2 = LH, 3 = LHU, 4 = LB, 5 = LBU, 7 = PC+4
- id_reg_wr_en, id_dmem_wr_en  out  1 each  write enables
- id_wr_byte_sel  out  2  00 = byte, 01 = half, 10 = word (stores)
- id_branch, id_jump  out  1 each  conditional branch / JAL-JALR
- id_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (rst = 1 at a clk edge): every id_* output = 0, alu_op = NOP, pend_cnt = 0, pend_rd = 0. if_ready is 0 while rst is high. Reset overrides flush and stall.
- Latency: 1 cycle. An instruction accepted at edge N appears on the id_* outputs after edge N.
- hold = id_valid & ~ex_ready.
- hazard = (pend_cnt != 0) & if_valid & ((uses_rs1 & rs1 == pend_rd) | (uses_rs2 & rs2 == pend_rd)). uses_rs1/uses_rs2 come from the decoded format; U/J formats use neither.
- if_ready = ~rst & ~ex_flush & ~hold & ~hazard.
- Register update priority, highest first:
  1. rst
  2. ex_flush: id_valid <= 0.
  3. hold: all id_* unchanged.
  4. hazard: id_valid <= 0 (bubble); other fields don't-care.
  5. if_valid & if_ready: load decoded fields, id_valid <= 1.
  6. Otherwise: id_valid <= 0.
- Load tracking:
  - When a load with rd != 0 is accepted: pend_rd <= rd, pend_cnt <= LOAD_LAT. A newer load overwrites the older one.
  - Otherwise pend_cnt decrements every cycle it is nonzero, including during flush and hold.
  - A hazard is therefore held for exactly LOAD_LAT bubble cycles when no back-pressure is applied.
- x0 rules:
  - rd == 0 forces id_reg_wr_en = 0.
  - Reads of x0 never raise a hazard, because pend_rd is never set to 0.
- Illegal encodings: unknown opcode, unused func3, or R-type func7 not in {0x00, 0x20, (0x01 when EN_M_EXT)}.
  - Result: id_illegal = 1, reg/dmem write enables = 0, alu_op = NOP, id_valid = 1 so EX can trap.
- Immediates:
  - I = sign-extended [31:20]
  - S = sign-extended {[31:25], [11:7]}
  - B = {sign, [7], [30:25], [11:8], 0}
  - U = {[31:12], 12'b0}
  - J = {sign, [19:12], [20], [30:21], 0}
  - All sign-extended to XLEN.
- LUI: op1_sel = zero, op2_sel = imm. AUIPC: op1_sel = PC, op2_sel = imm. JAL: wb_sel = 7, jump = 1. JALR: wb_sel = 7, jump = 1.
- Shift-immediates: func7[5] selects SRA vs SRL. func7 bits other than [5] nonzero → illegal.
- Simultaneous flush + hazard: the flush wins; no bubble accounting is needed.

Decomposition:
- Package rv_pkg holds:
  - opcode constants
  - func3/func7 constants
  - ALU op codes, including NOP and the M-extension ops
  - op1/op2/wb select enums
  - LOAD_LAT legal range
- Sub-module rv_decode_comb (purely combinational): instr → decoded struct plus uses_rs1/uses_rs2/illegal.
- rv_decode_stage owns the handshake, hazard counter and ID/EX register.

Test Plan:
- Reset, then if_instr = 0x00500093 (addi x1,x0,5), ex_ready = 1 → next cycle id_valid = 1, rd = 1, imm = 5, op2_sel = imm, reg_wr_en = 1.
- Issue 0x0000A103 (lw x2,0(x1)), then 0x001101B3 (add x3,x2,x1), LOAD_LAT = 1 → if_ready = 0 for 1 cycle, one bubble, then add issued. Repeat with LOAD_LAT = 3 → 3 bubbles.
- ex_ready = 0 for 4 cycles while id_valid = 1 → all id_* stable and if_ready = 0; release → next instruction accepted in that same cycle.
- ex_flush = 1 while if_valid = 1 → instruction not accepted, id_valid = 0 next cycle. rst asserted mid-stall → all outputs 0 and pend_cnt = 0.
- 0x022082B3 (mul x5,x1,x2): EN_M_EXT = 1 → MUL alu_op, illegal = 0; EN_M_EXT = 0 → illegal = 1, reg_wr_en = 0. 0xFFFFFFFF → illegal = 1.
- 0x008000EF (jal x1,+8) → jump = 1, imm = 8, wb_sel = 7, op1_sel = PC. Same encoding with rd = 0 → reg_wr_en = 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, function fields, ALU op encoding, operand and
// writeback selects, and the decoded-instruction record handed from decoder to ID/EX register.
package rv_pkg;

  localparam int unsigned ILEN       = 32;
  localparam int unsigned LoadLatMin = 1;
  localparam int unsigned LoadLatMax = 3;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [6:0] F7Base   = 7'h00;
  localparam logic [6:0] F7Alt    = 7'h20;
  localparam logic [6:0] F7MulDiv = 7'h01;

  // AluNop must stay at zero: the ID/EX register resets to all-zeros.
  typedef enum logic [6:0] {
    AluNop    = 7'd0,
    AluAdd    = 7'd1,
    AluSub    = 7'd2,
    AluSll    = 7'd3,
    AluSlt    = 7'd4,
    AluSltu   = 7'd5,
    AluXor    = 7'd6,
    AluSrl    = 7'd7,
    AluSra    = 7'd8,
    AluOr     = 7'd9,
    AluAnd    = 7'd10,
    AluBeq    = 7'd16,
    AluBne    = 7'd17,
    AluBlt    = 7'd18,
    AluBge    = 7'd19,
    AluBltu   = 7'd20,
    AluBgeu   = 7'd21,
    AluMul    = 7'd32,
    AluMulh   = 7'd33,
    AluMulhsu = 7'd34,
    AluMulhu  = 7'd35,
    AluDiv    = 7'd36,
    AluDivu   = 7'd37,
    AluRem    = 7'd38,
    AluRemu   = 7'd39
  } alu_op_e;

  typedef enum logic [1:0] {Op1Rs1 = 2'd0, Op1Pc = 2'd1, Op1Zero = 2'd2} op1_sel_e;
  typedef enum logic [1:0] {Op2Rs2 = 2'd0, Op2Imm = 2'd1, Op2Four = 2'd2} op2_sel_e;

  typedef enum logic [2:0] {
    WbAlu = 3'd0,
    WbLw  = 3'd1,
    WbLh  = 3'd2,
    WbLhu = 3'd3,
    WbLb  = 3'd4,
    WbLbu = 3'd5,
    WbPc4 = 3'd7
  } wb_sel_e;

  typedef struct packed {
    alu_op_e           alu_op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [ILEN-1:0]   imm;
    op1_sel_e          op1_sel;
    op2_sel_e          op2_sel;
    wb_sel_e           wb_sel;
    logic              reg_wr_en;
    logic              dmem_wr_en;
    logic [1:0]        wr_byte_sel;
    logic              branch;
    logic              jump;
  } decoded_t;

  // Integer ALU op for OP / OP-IMM; alt picks SUB/SRA.
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      F3AddSub: alu_base = alt ? AluSub : AluAdd;
      F3Sll:    alu_base = AluSll;
      F3Slt:    alu_base = AluSlt;
      F3Sltu:   alu_base = AluSltu;
      F3Xor:    alu_base = AluXor;
      F3SrlSra: alu_base = alt ? AluSra : AluSrl;
      F3Or:     alu_base = AluOr;
      default:  alu_base = AluAnd;
    endcase
  endfunction

  function automatic alu_op_e alu_muldiv(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_muldiv = AluMul;
      3'b001:  alu_muldiv = AluMulh;
      3'b010:  alu_muldiv = AluMulhsu;
      3'b011:  alu_muldiv = AluMulhu;
      3'b100:  alu_muldiv = AluDiv;
      3'b101:  alu_muldiv = AluDivu;
      3'b110:  alu_muldiv = AluRem;
      default: alu_muldiv = AluRemu;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word to decoded record, register-use flags,
// load marker and illegal-encoding flag.
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b0
) (
  input  logic [ILEN-1:0] instr,
  output decoded_t        dec,
  output logic            is_load,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [ILEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.alu_op  = AluAdd;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.op1_sel = Op1Rs1;
    dec.op2_sel = Op2Imm;
    dec.wb_sel  = WbAlu;
    is_load     = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    illegal     = 1'b0;

    unique case (opcode)
      OpcLui: begin
        dec.imm       = imm_u;
        dec.op1_sel   = Op1Zero;
        dec.reg_wr_en = 1'b1;
      end
      OpcAuipc: begin
        dec.imm       = imm_u;
        dec.op1_sel   = Op1Pc;
        dec.reg_wr_en = 1'b1;
      end
      OpcJal: begin
        // ALU forms the target; the link value comes through the PC+4 writeback path.
        dec.imm       = imm_j;
        dec.op1_sel   = Op1Pc;
        dec.wb_sel    = WbPc4;
        dec.jump      = 1'b1;
        dec.reg_wr_en = 1'b1;
      end
      OpcJalr: begin
        dec.imm       = imm_i;
        dec.wb_sel    = WbPc4;
        dec.jump      = 1'b1;
        dec.reg_wr_en = 1'b1;
        uses_rs1      = 1'b1;
        illegal       = (f3 != 3'b000);
      end
      OpcBranch: begin
        dec.imm     = imm_b;
        dec.op2_sel = Op2Rs2;
        dec.branch  = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        case (f3)
          F3Beq:   dec.alu_op = AluBeq;
          F3Bne:   dec.alu_op = AluBne;
          F3Blt:   dec.alu_op = AluBlt;
          F3Bge:   dec.alu_op = AluBge;
          F3Bltu:  dec.alu_op = AluBltu;
          F3Bgeu:  dec.alu_op = AluBgeu;
          default: illegal    = 1'b1;
        endcase
      end
      OpcLoad: begin
        dec.imm       = imm_i;
        dec.reg_wr_en = 1'b1;
        is_load       = 1'b1;
        uses_rs1      = 1'b1;
        case (f3)
          F3Byte:  dec.wb_sel = WbLb;
          F3Half:  dec.wb_sel = WbLh;
          F3Word:  dec.wb_sel = WbLw;
          F3ByteU: dec.wb_sel = WbLbu;
          F3HalfU: dec.wb_sel = WbLhu;
          default: illegal    = 1'b1;
        endcase
      end
      OpcStore: begin
        dec.imm        = imm_s;
        dec.dmem_wr_en = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        case (f3)
          F3Byte:  dec.wr_byte_sel = 2'b00;
          F3Half:  dec.wr_byte_sel = 2'b01;
          F3Word:  dec.wr_byte_sel = 2'b10;
          default: illegal         = 1'b1;
        endcase
      end
      OpcOpImm: begin
        dec.imm       = imm_i;
        dec.reg_wr_en = 1'b1;
        uses_rs1      = 1'b1;
        if (f3 == F3Sll) begin
          dec.alu_op = AluSll;
          illegal    = (f7 != F7Base);
        end else if (f3 == F3SrlSra) begin
          dec.alu_op = alu_base(f3, f7[5]);
          illegal    = ((f7 & ~F7Alt) != 7'd0);
        end else begin
          dec.alu_op = alu_base(f3, 1'b0);
        end
      end
      OpcOp: begin
        dec.op2_sel   = Op2Rs2;
        dec.reg_wr_en = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        if (f7 == F7Base) begin
          dec.alu_op = alu_base(f3, 1'b0);
        end else if (f7 == F7Alt && (f3 == F3AddSub || f3 == F3SrlSra)) begin
          dec.alu_op = alu_base(f3, 1'b1);
        end else if (f7 == F7MulDiv && EN_M_EXT) begin
          dec.alu_op = alu_muldiv(f3);
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions still flow to EX to trap, but must have no side effects.
    if (illegal) begin
      dec.alu_op     = AluNop;
      dec.reg_wr_en  = 1'b0;
      dec.dmem_wr_en = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      is_load        = 1'b0;
      uses_rs1       = 1'b0;
      uses_rs2       = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_wr_en = 1'b0;
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake, load-use interlock and the ID/EX
// register between fetch and execute.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_M_EXT = 1'b0,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output alu_op_e         id_alu_op,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output op1_sel_e        id_op1_sel,
  output op2_sel_e        id_op2_sel,
  output wb_sel_e         id_wb_sel,
  output logic            id_reg_wr_en,
  output logic            id_dmem_wr_en,
  output logic [1:0]      id_wr_byte_sel,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal
);

  localparam int unsigned CntW       = $clog2(LoadLatMax + 1);
  localparam int unsigned LoadLatEff = (LOAD_LAT < LoadLatMin) ? LoadLatMin :
                                       (LOAD_LAT > LoadLatMax) ? LoadLatMax : LOAD_LAT;
  localparam logic [CntW-1:0] LoadLatCnt = CntW'(LoadLatEff);

  decoded_t        dec, dec_d, dec_q;
  logic            dec_load, uses_rs1, uses_rs2, dec_illegal;
  logic            valid_d, valid_q, illegal_d, illegal_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [CntW-1:0] pend_cnt_d, pend_cnt_q;
  logic [4:0]      pend_rd_d, pend_rd_q;
  logic            hold, hazard, accept;

  rv_decode_comb #(
    .EN_M_EXT (EN_M_EXT)
  ) u_decode (
    .instr    (if_instr),
    .dec      (dec),
    .is_load  (dec_load),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (dec_illegal)
  );

  assign hold   = valid_q & ~ex_ready;
  // pend_rd is never x0, so reads of x0 cannot match.
  assign hazard = (pend_cnt_q != '0) & if_valid &
                  ((uses_rs1 & (dec.rs1 == pend_rd_q)) | (uses_rs2 & (dec.rs2 == pend_rd_q)));
  assign if_ready = ~rst & ~ex_flush & ~hold & ~hazard;
  assign accept   = if_valid & if_ready;

  always_comb begin
    valid_d   = valid_q;
    dec_d     = dec_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    if (ex_flush) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      if (accept) begin
        valid_d   = 1'b1;
        dec_d     = dec;
        illegal_d = dec_illegal;
        pc_d      = if_pc;
      end else begin
        valid_d = 1'b0;
      end
    end

    pend_cnt_d = pend_cnt_q;
    pend_rd_d  = pend_rd_q;
    if (accept && dec_load && (dec.rd != 5'd0)) begin
      pend_rd_d  = dec.rd;
      pend_cnt_d = LoadLatCnt;
    end else if (pend_cnt_q != '0) begin
      pend_cnt_d = pend_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      dec_q      <= '0;
      illegal_q  <= 1'b0;
      pc_q       <= '0;
      pend_cnt_q <= '0;
      pend_rd_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      dec_q      <= dec_d;
      illegal_q  <= illegal_d;
      pc_q       <= pc_d;
      pend_cnt_q <= pend_cnt_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  assign id_valid       = valid_q;
  assign id_pc          = pc_q;
  assign id_alu_op      = dec_q.alu_op;
  assign id_rs1         = dec_q.rs1;
  assign id_rs2         = dec_q.rs2;
  assign id_rd          = dec_q.rd;
  assign id_imm         = XLEN'($signed(dec_q.imm));
  assign id_op1_sel     = dec_q.op1_sel;
  assign id_op2_sel     = dec_q.op2_sel;
  assign id_wb_sel      = dec_q.wb_sel;
  assign id_reg_wr_en   = dec_q.reg_wr_en;
  assign id_dmem_wr_en  = dec_q.dmem_wr_en;
  assign id_wr_byte_sel = dec_q.wr_byte_sel;
  assign id_branch      = dec_q.branch;
  assign id_jump        = dec_q.jump;
  assign id_illegal     = illegal_q;

endmodule
